// File: rtl/fifo_checker.sv
`default_nettype none
// ============================================================================
// Module   : fifo_checker
// Purpose  : Cycle-accurate scoreboard / protocol checker for a synchronous
//            FIFO. Snoops every FIFO pin, keeps a shadow FIFO model, compares
//            data and all status flags every checked cycle, keeps saturating
//            correct/error counters and latches the first failure (code and
//            cycle) for debug or emulation readout.
// Ports    : clk, rst            - clock / synchronous active-high reset
//            mon_en_i            - checking enable
//            clr_counts_i        - clear counters, first-error capture; re-arm
//            dut_rst_n_i         - DUT reset (active low) as seen at the DUT
//            wr_en_i, rd_en_i    - DUT request inputs
//            data_in_i           - DUT write data
//            data_out_i          - DUT registered read data
//            wr_ack_i, overflow_i, underflow_i - DUT registered status
//            full_i, almostfull_i, empty_i, almostempty_i - DUT flags
//            correct_count_o     - checked cycles without mismatch
//            error_count_o       - checked cycles with >=1 mismatch
//            err_sticky_o        - set on first mismatch
//            first_err_code_o    - code of first mismatch (0 = none)
//            first_err_cycle_o   - internal cycle count at first mismatch
//            shadow_count_o      - shadow FIFO occupancy
//            state_o             - 0 IDLE, 1 ARMED, 2 CHECK, 3 HALT
// Error codes: 1 data, 2 wr_ack, 3 overflow, 4 underflow, 5 full,
//              6 almostfull, 7 empty, 8 almostempty (lowest code wins)
// Revision : 1.0 - initial release
// ============================================================================
module fifo_checker #(
  parameter int         DATA_WIDTH  = 16,
  parameter int         FIFO_DEPTH  = 8,
  parameter int         CNT_WIDTH   = 32,
  parameter bit         STOP_ON_ERR = 1'b0,
  parameter logic [4:0] CHECK_MASK  = 5'b11111
) (
  input  logic                          clk,
  input  logic                          rst,
  input  logic                          mon_en_i,
  input  logic                          clr_counts_i,
  input  logic                          dut_rst_n_i,
  input  logic                          wr_en_i,
  input  logic                          rd_en_i,
  input  logic [DATA_WIDTH-1:0]         data_in_i,
  input  logic [DATA_WIDTH-1:0]         data_out_i,
  input  logic                          wr_ack_i,
  input  logic                          overflow_i,
  input  logic                          underflow_i,
  input  logic                          full_i,
  input  logic                          almostfull_i,
  input  logic                          empty_i,
  input  logic                          almostempty_i,
  output logic [CNT_WIDTH-1:0]          correct_count_o,
  output logic [CNT_WIDTH-1:0]          error_count_o,
  output logic                          err_sticky_o,
  output logic [3:0]                    first_err_code_o,
  output logic [CNT_WIDTH-1:0]          first_err_cycle_o,
  output logic [$clog2(FIFO_DEPTH):0]   shadow_count_o,
  output logic [1:0]                    state_o
);

  localparam int AW = $clog2(FIFO_DEPTH);
  localparam int OW = AW + 1;

  localparam logic [1:0] S_IDLE  = 2'd0;
  localparam logic [1:0] S_ARMED = 2'd1;
  localparam logic [1:0] S_CHECK = 2'd2;
  localparam logic [1:0] S_HALT  = 2'd3;

  localparam logic [OW-1:0] OCC_FULL  = OW'(FIFO_DEPTH);
  localparam logic [OW-1:0] OCC_AFULL = OW'(FIFO_DEPTH - 1);
  localparam logic [OW-1:0] OCC_ONE   = OW'(1);

  localparam logic [CNT_WIDTH-1:0] CNT_ONE = CNT_WIDTH'(1);
  localparam logic [CNT_WIDTH-1:0] CNT_MAX = {CNT_WIDTH{1'b1}};

  // Bit positions in the mismatch vector; error code = position + 1.
  localparam int M_DATA   = 0;
  localparam int M_ACK    = 1;
  localparam int M_OVF    = 2;
  localparam int M_UDF    = 3;
  localparam int M_FULL   = 4;
  localparam int M_AFULL  = 5;
  localparam int M_EMPTY  = 6;
  localparam int M_AEMPTY = 7;

  // --------------------------------------------------------------------------
  // State and registers
  // --------------------------------------------------------------------------
  logic [1:0]            state_q, state_d;
  logic                  seen_rst_q, seen_rst_d;

  logic [DATA_WIDTH-1:0] mem_q [FIFO_DEPTH];
  logic [AW-1:0]         wr_ptr_q, wr_ptr_d;
  logic [AW-1:0]         rd_ptr_q, rd_ptr_d;
  logic [OW-1:0]         occ_q, occ_d;

  logic                  exp_ack_q, exp_ack_d;
  logic                  exp_ovf_q, exp_ovf_d;
  logic                  exp_udf_q, exp_udf_d;
  logic                  rd_acc_q, rd_acc_d;
  logic [DATA_WIDTH-1:0] data_exp_q, data_exp_d;

  logic [CNT_WIDTH-1:0]  correct_q, correct_d;
  logic [CNT_WIDTH-1:0]  error_q, error_d;
  logic [CNT_WIDTH-1:0]  cycle_q, cycle_d;
  logic [CNT_WIDTH-1:0]  ecycle_q, ecycle_d;
  logic                  sticky_q, sticky_d;
  logic [3:0]            code_q, code_d;

  // --------------------------------------------------------------------------
  // Combinational wires
  // --------------------------------------------------------------------------
  logic                  w_in_check;
  logic                  w_halted;
  logic                  w_track;
  logic                  w_full_exp, w_afull_exp, w_empty_exp, w_aempty_exp;
  logic                  w_wr_acc, w_rd_acc;
  logic [7:0]            w_mis;
  logic                  w_err;
  logic [3:0]            w_code;

  function automatic logic [CNT_WIDTH-1:0] sat_inc(input logic [CNT_WIDTH-1:0] v);
    return (v == CNT_MAX) ? v : v + CNT_ONE;
  endfunction

  // --------------------------------------------------------------------------
  // FSM: state register
  // --------------------------------------------------------------------------
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= S_IDLE;
      seen_rst_q <= 1'b0;
    end else begin
      state_q    <= state_d;
      seen_rst_q <= seen_rst_d;
    end
  end

  // --------------------------------------------------------------------------
  // FSM: next-state logic
  // HALT is sticky and can only be left by rst or clr_counts; clr_counts
  // always returns to IDLE so the checker re-arms on the next DUT reset.
  // --------------------------------------------------------------------------
  always_comb begin
    state_d = state_q;
    if (clr_counts_i) begin
      state_d = S_IDLE;
    end else if (state_q == S_HALT) begin
      state_d = S_HALT;
    end else if (!mon_en_i) begin
      state_d = S_IDLE;
    end else begin
      case (state_q)
        S_IDLE:  state_d = S_ARMED;
        S_ARMED: if (seen_rst_q && dut_rst_n_i) state_d = S_CHECK;
        S_CHECK: if (STOP_ON_ERR && w_err) state_d = S_HALT;
        default: state_d = state_q;
      endcase
    end
    // Remember a DUT reset cycle only while waiting in ARMED.
    seen_rst_d = (state_q == S_ARMED && state_d == S_ARMED) ?
                 (seen_rst_q | ~dut_rst_n_i) : 1'b0;
  end

  // --------------------------------------------------------------------------
  // FSM: output / qualifier logic
  // --------------------------------------------------------------------------
  always_comb begin
    state_o    = state_q;
    w_in_check = (state_q == S_CHECK);
    w_halted   = (state_q == S_HALT);
    // A tracked cycle both updates the shadow and is compared/counted.
    w_track    = w_in_check & mon_en_i & dut_rst_n_i & ~clr_counts_i;
  end

  // --------------------------------------------------------------------------
  // Shadow FIFO expectations
  // --------------------------------------------------------------------------
  assign w_full_exp   = (occ_q == OCC_FULL);
  assign w_afull_exp  = (occ_q == OCC_AFULL);
  assign w_empty_exp  = (occ_q == '0);
  assign w_aempty_exp = (occ_q == OCC_ONE);

  // Full blocks the write and empty blocks the read, so simultaneous
  // requests degrade to a single operation at the boundaries.
  assign w_wr_acc = wr_en_i & ~w_full_exp;
  assign w_rd_acc = rd_en_i & ~w_empty_exp;

  always_comb begin
    wr_ptr_d   = wr_ptr_q;
    rd_ptr_d   = rd_ptr_q;
    occ_d      = occ_q;
    exp_ack_d  = exp_ack_q;
    exp_ovf_d  = exp_ovf_q;
    exp_udf_d  = exp_udf_q;
    rd_acc_d   = rd_acc_q;
    data_exp_d = data_exp_q;
    if (clr_counts_i || (!w_track && !w_halted)) begin
      // Outside CHECK (or during a DUT reset) the shadow mirrors an empty,
      // freshly reset FIFO. HALT keeps the shadow frozen for inspection.
      wr_ptr_d   = '0;
      rd_ptr_d   = '0;
      occ_d      = '0;
      exp_ack_d  = 1'b0;
      exp_ovf_d  = 1'b0;
      exp_udf_d  = 1'b0;
      rd_acc_d   = 1'b0;
      data_exp_d = '0;
    end else if (w_track) begin
      wr_ptr_d  = wr_ptr_q + AW'(w_wr_acc);
      rd_ptr_d  = rd_ptr_q + AW'(w_rd_acc);
      occ_d     = occ_q + OW'(w_wr_acc) - OW'(w_rd_acc);
      exp_ack_d = w_wr_acc;
      exp_ovf_d = wr_en_i & w_full_exp;
      exp_udf_d = rd_en_i & w_empty_exp;
      rd_acc_d  = w_rd_acc;
      if (w_rd_acc) begin
        data_exp_d = mem_q[rd_ptr_q];
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr_q   <= '0;
      rd_ptr_q   <= '0;
      occ_q      <= '0;
      exp_ack_q  <= 1'b0;
      exp_ovf_q  <= 1'b0;
      exp_udf_q  <= 1'b0;
      rd_acc_q   <= 1'b0;
      data_exp_q <= '0;
    end else begin
      wr_ptr_q   <= wr_ptr_d;
      rd_ptr_q   <= rd_ptr_d;
      occ_q      <= occ_d;
      exp_ack_q  <= exp_ack_d;
      exp_ovf_q  <= exp_ovf_d;
      exp_udf_q  <= exp_udf_d;
      rd_acc_q   <= rd_acc_d;
      data_exp_q <= data_exp_d;
    end
  end

  // Shadow storage is pure datapath; validity is tracked by the pointers.
  always_ff @(posedge clk) begin
    if (w_track && w_wr_acc) begin
      mem_q[wr_ptr_q] <= data_in_i;
    end
  end

  // --------------------------------------------------------------------------
  // Comparison
  // Registered DUT outputs are compared against expectations formed in the
  // previous tracked cycle; flags are compared against the current occupancy.
  // --------------------------------------------------------------------------
  always_comb begin
    w_mis           = '0;
    w_mis[M_DATA]   = CHECK_MASK[0] & rd_acc_q & (data_out_i != data_exp_q);
    w_mis[M_ACK]    = CHECK_MASK[1] & (wr_ack_i    != exp_ack_q);
    w_mis[M_OVF]    = CHECK_MASK[2] & (overflow_i  != exp_ovf_q);
    w_mis[M_UDF]    = CHECK_MASK[2] & (underflow_i != exp_udf_q);
    w_mis[M_FULL]   = CHECK_MASK[3] & (full_i        != w_full_exp);
    w_mis[M_AFULL]  = CHECK_MASK[3] & (almostfull_i  != w_afull_exp);
    w_mis[M_EMPTY]  = CHECK_MASK[4] & (empty_i       != w_empty_exp);
    w_mis[M_AEMPTY] = CHECK_MASK[4] & (almostempty_i != w_aempty_exp);
  end

  assign w_err = w_track & (|w_mis);

  // Lowest-numbered mismatch wins: scan from the top so the last hit is lowest.
  always_comb begin
    w_code = 4'd0;
    for (int i = 7; i >= 0; i--) begin
      if (w_mis[i]) begin
        w_code = 4'(i + 1);
      end
    end
  end

  // --------------------------------------------------------------------------
  // Counters and first-error capture (clr_counts beats same-cycle updates)
  // --------------------------------------------------------------------------
  always_comb begin
    correct_d = correct_q;
    error_d   = error_q;
    cycle_d   = cycle_q;
    ecycle_d  = ecycle_q;
    sticky_d  = sticky_q;
    code_d    = code_q;
    if (clr_counts_i) begin
      correct_d = '0;
      error_d   = '0;
      cycle_d   = '0;
      ecycle_d  = '0;
      sticky_d  = 1'b0;
      code_d    = 4'd0;
    end else begin
      if (w_track) begin
        if (w_err) begin
          error_d = sat_inc(error_q);
        end else begin
          correct_d = sat_inc(correct_q);
        end
      end
      if (w_err && !sticky_q) begin
        sticky_d = 1'b1;
        code_d   = w_code;
        ecycle_d = cycle_q;
      end
      if (w_in_check) begin
        cycle_d = sat_inc(cycle_q);
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      correct_q <= '0;
      error_q   <= '0;
      cycle_q   <= '0;
      ecycle_q  <= '0;
      sticky_q  <= 1'b0;
      code_q    <= 4'd0;
    end else begin
      correct_q <= correct_d;
      error_q   <= error_d;
      cycle_q   <= cycle_d;
      ecycle_q  <= ecycle_d;
      sticky_q  <= sticky_d;
      code_q    <= code_d;
    end
  end

  assign correct_count_o   = correct_q;
  assign error_count_o     = error_q;
  assign err_sticky_o      = sticky_q;
  assign first_err_code_o  = code_q;
  assign first_err_cycle_o = ecycle_q;
  assign shadow_count_o    = occ_q;

endmodule
`default_nettype wire

// File: tb/tb_fifo_checker.sv
`default_nettype none
// ============================================================================
// Module   : tb_fifo_checker
// Purpose  : Self-checking bench for fifo_checker. A behavioural FIFO (queue)
//            drives the snooped pins, optionally with injected pin faults, and
//            a queue/counter reference model predicts every checker output.
//            Two checkers share the pins: one free-running with all checks
//            enabled, one that halts on error with full/almostfull masked.
// Revision : 1.0 - initial release
// ============================================================================
module tb_fifo_checker;

  localparam int DW     = 16;
  localparam int D      = 8;
  localparam int CW     = 8;
  localparam int SATMAX = 255;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic          rst, mon_en, clr_counts, dut_rst_n, wr_en, rd_en;
  logic [DW-1:0] data_in, data_out;
  logic          wr_ack, overflow, underflow, full, almostfull, empty, almostempty;

  logic [1:0][CW-1:0] cc_o, ec_o, fec_o;
  logic [1:0]         sticky_o;
  logic [1:0][3:0]    code_o, shc_o;
  logic [1:0][1:0]    st_o;

  fifo_checker #(.DATA_WIDTH(DW), .FIFO_DEPTH(D), .CNT_WIDTH(CW),
                 .STOP_ON_ERR(1'b0), .CHECK_MASK(5'b11111)) u_chk_run (
    .clk(clk), .rst(rst), .mon_en_i(mon_en), .clr_counts_i(clr_counts),
    .dut_rst_n_i(dut_rst_n), .wr_en_i(wr_en), .rd_en_i(rd_en),
    .data_in_i(data_in), .data_out_i(data_out), .wr_ack_i(wr_ack),
    .overflow_i(overflow), .underflow_i(underflow), .full_i(full),
    .almostfull_i(almostfull), .empty_i(empty), .almostempty_i(almostempty),
    .correct_count_o(cc_o[0]), .error_count_o(ec_o[0]), .err_sticky_o(sticky_o[0]),
    .first_err_code_o(code_o[0]), .first_err_cycle_o(fec_o[0]),
    .shadow_count_o(shc_o[0]), .state_o(st_o[0]));

  fifo_checker #(.DATA_WIDTH(DW), .FIFO_DEPTH(D), .CNT_WIDTH(CW),
                 .STOP_ON_ERR(1'b1), .CHECK_MASK(5'b10111)) u_chk_halt (
    .clk(clk), .rst(rst), .mon_en_i(mon_en), .clr_counts_i(clr_counts),
    .dut_rst_n_i(dut_rst_n), .wr_en_i(wr_en), .rd_en_i(rd_en),
    .data_in_i(data_in), .data_out_i(data_out), .wr_ack_i(wr_ack),
    .overflow_i(overflow), .underflow_i(underflow), .full_i(full),
    .almostfull_i(almostfull), .empty_i(empty), .almostempty_i(almostempty),
    .correct_count_o(cc_o[1]), .error_count_o(ec_o[1]), .err_sticky_o(sticky_o[1]),
    .first_err_code_o(code_o[1]), .first_err_cycle_o(fec_o[1]),
    .shadow_count_o(shc_o[1]), .state_o(st_o[1]));

  // Behavioural FIFO driving the pins
  logic [DW-1:0] q[$];
  logic          f_ack, f_ovf, f_udf;
  logic [DW-1:0] f_dout;
  logic [7:0]    flt;   // bit k inverts the pin checked under error code k+1

  // Reference model of each checker
  int m_state[2], m_correct[2], m_error[2], m_code[2], m_ecyc[2], m_cyc[2], m_shadow[2];
  bit m_sticky[2], m_seen[2], m_rdprev[2];

  int n_checks = 0;
  int n_errors = 0;

  task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_errors++;
      $display("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  function automatic bit fault_visible(input int i, input int k);
    if (k == 0) return m_rdprev[i];              // data only after a read
    if (i == 1 && (k == 4 || k == 5)) return 0;  // masked group on checker 1
    return 1;
  endfunction

  function automatic int sat(input int v);
    return (v > SATMAX) ? SATMAX : v;
  endfunction

  task automatic model_update(input int i, input bit racc);
    bit trk;
    int code, nxt;
    if (rst) begin
      m_state[i] = 0; m_correct[i] = 0; m_error[i] = 0; m_code[i] = 0; m_ecyc[i] = 0;
      m_cyc[i] = 0; m_shadow[i] = 0; m_sticky[i] = 0; m_seen[i] = 0; m_rdprev[i] = 0;
      return;
    end
    trk  = (m_state[i] == 2) && mon_en && dut_rst_n && !clr_counts;
    code = 0;
    if (trk)
      for (int k = 7; k >= 0; k--)
        if (flt[k] && fault_visible(i, k)) code = k + 1;
    if (clr_counts) begin
      m_state[i] = 0; m_correct[i] = 0; m_error[i] = 0; m_code[i] = 0; m_ecyc[i] = 0;
      m_cyc[i] = 0; m_shadow[i] = 0; m_sticky[i] = 0; m_seen[i] = 0; m_rdprev[i] = 0;
      return;
    end
    if (trk) begin
      if (code != 0) begin
        m_error[i] = sat(m_error[i] + 1);
        if (!m_sticky[i]) begin
          m_sticky[i] = 1; m_code[i] = code; m_ecyc[i] = m_cyc[i];
        end
      end else begin
        m_correct[i] = sat(m_correct[i] + 1);
      end
    end
    if (m_state[i] == 2) m_cyc[i] = sat(m_cyc[i] + 1);
    nxt = m_state[i];
    if (m_state[i] != 3) begin
      if (!mon_en) nxt = 0;
      else if (m_state[i] == 0) nxt = 1;
      else if (m_state[i] == 1 && m_seen[i] && dut_rst_n) nxt = 2;
      else if (m_state[i] == 2 && i == 1 && code != 0) nxt = 3;
    end
    m_seen[i] = (m_state[i] == 1 && nxt == 1) && (m_seen[i] || !dut_rst_n);
    if (trk) m_shadow[i] = q.size();
    else if (m_state[i] != 3) m_shadow[i] = 0;
    m_rdprev[i] = trk && racc;
    m_state[i]  = nxt;
  endtask

  task automatic compare_all();
    for (int i = 0; i < 2; i++) begin
      check_eq($sformatf("c%0d.correct_count", i), 32'(cc_o[i]), m_correct[i]);
      check_eq($sformatf("c%0d.error_count", i), 32'(ec_o[i]), m_error[i]);
      check_eq($sformatf("c%0d.err_sticky", i), 32'(sticky_o[i]), 32'(m_sticky[i]));
      check_eq($sformatf("c%0d.first_err_code", i), 32'(code_o[i]), m_code[i]);
      check_eq($sformatf("c%0d.first_err_cycle", i), 32'(fec_o[i]), m_ecyc[i]);
      check_eq($sformatf("c%0d.shadow_count", i), 32'(shc_o[i]), m_shadow[i]);
      check_eq($sformatf("c%0d.state", i), 32'(st_o[i]), m_state[i]);
    end
  endtask

  // One clock: drive pins from the behavioural FIFO, clock, update, compare.
  task automatic step(input bit w, input bit r, input logic [DW-1:0] d);
    int occ;
    bit wacc, racc;
    occ         = q.size();
    wr_en       = w;
    rd_en       = r;
    data_in     = d;
    full        = (occ == D)     ^ flt[4];
    almostfull  = (occ == D - 1) ^ flt[5];
    empty       = (occ == 0)     ^ flt[6];
    almostempty = (occ == 1)     ^ flt[7];
    wr_ack      = f_ack ^ flt[1];
    overflow    = f_ovf ^ flt[2];
    underflow   = f_udf ^ flt[3];
    data_out    = f_dout ^ {{(DW-1){1'b0}}, flt[0]};
    wacc = w && (occ < D);
    racc = r && (occ > 0);
    @(posedge clk);
    if (!dut_rst_n) begin
      q.delete();
      f_ack = 0; f_ovf = 0; f_udf = 0; f_dout = '0;
    end else begin
      if (racc) f_dout = q.pop_front();
      if (wacc) q.push_back(d);
      f_ack = wacc;
      f_ovf = w && (occ == D);
      f_udf = r && (occ == 0);
    end
    for (int i = 0; i < 2; i++) model_update(i, racc);
    flt = '0;
    #1;
    compare_all();
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) step(1'b0, 1'b0, '0);
  endtask

  // Enable, hold the DUT in reset for two cycles and release it.
  task automatic arm();
    mon_en    = 1'b1;
    dut_rst_n = 1'b1;
    idle(1);
    dut_rst_n = 1'b0;
    idle(2);
    dut_rst_n = 1'b1;
    idle(1);
  endtask

  int            rd3_cyc, halt_cc, halt_ec, k;
  logic [DW-1:0] rv;

  initial begin
    rst = 1'b1; mon_en = 1'b0; clr_counts = 1'b0; dut_rst_n = 1'b0;
    wr_en = 1'b0; rd_en = 1'b0; data_in = '0; flt = '0;
    f_ack = 0; f_ovf = 0; f_udf = 0; f_dout = '0;
    idle(3);
    check_eq("reset.state", 32'(st_o[0]), 0);
    check_eq("reset.correct", 32'(cc_o[0]), 0);
    rst = 1'b0;
    idle(2);

    arm();
    check_eq("arm.state0", 32'(st_o[0]), 2);
    check_eq("arm.state1", 32'(st_o[1]), 2);
    idle(1);

    // Fill with 1..8, then one write while full
    for (int v = 1; v <= 8; v++) step(1'b1, 1'b0, DW'(v));
    check_eq("fill.shadow", 32'(shc_o[0]), 8);
    step(1'b1, 1'b0, 16'h0009);
    idle(1);
    check_eq("ovf.errors", 32'(ec_o[0]), 0);

    // Drain, then one read while empty
    for (int v = 1; v <= 8; v++) step(1'b0, 1'b1, '0);
    idle(1);
    step(1'b0, 1'b1, '0);
    idle(1);
    check_eq("drain.shadow", 32'(shc_o[0]), 0);
    check_eq("udf.errors", 32'(ec_o[0]), 0);

    // Pointer wrap with simultaneous traffic
    for (int v = 0; v < 6; v++) step(1'b1, 1'b0, DW'(16'h0100 + v));
    for (int v = 0; v < 4; v++) step(1'b0, 1'b1, '0);
    for (int v = 0; v < 6; v++) step(1'b1, 1'b0, DW'(16'h0200 + v));
    for (int v = 0; v < 8; v++) step(1'b1, 1'b1, DW'(16'h0300 + v));
    for (int v = 0; v < 9; v++) step(1'b0, 1'b1, '0);
    idle(1);
    check_eq("wrap.errors0", 32'(ec_o[0]), 0);
    check_eq("wrap.errors1", 32'(ec_o[1]), 0);

    // Corrupt the data returned by the 3rd read
    for (int v = 1; v <= 4; v++) step(1'b1, 1'b0, DW'(v));
    step(1'b0, 1'b1, '0);
    step(1'b0, 1'b1, '0);
    rd3_cyc = m_cyc[0];
    step(1'b0, 1'b1, '0);
    flt[0] = 1'b1;
    step(1'b0, 1'b1, '0);
    check_eq("dflt.errors", 32'(ec_o[0]), 1);
    check_eq("dflt.sticky", 32'(sticky_o[0]), 1);
    check_eq("dflt.code", 32'(code_o[0]), 1);
    check_eq("dflt.cycle", 32'(fec_o[0]), 32'(rd3_cyc + 1));
    check_eq("dflt.halt", 32'(st_o[1]), 3);
    halt_cc = m_correct[1];
    halt_ec = m_error[1];

    // A second (full-flag) error: counted, first capture unchanged
    flt[4] = 1'b1;
    step(1'b1, 1'b0, 16'h00aa);
    idle(2);
    check_eq("ffl.errors", 32'(ec_o[0]), 2);
    check_eq("ffl.code", 32'(code_o[0]), 1);
    check_eq("halt.frozen_cc", 32'(cc_o[1]), halt_cc);
    check_eq("halt.frozen_ec", 32'(ec_o[1]), halt_ec);

    // Clear and re-arm
    clr_counts = 1'b1;
    step(1'b0, 1'b0, '0);
    clr_counts = 1'b0;
    check_eq("clr.state1", 32'(st_o[1]), 0);
    check_eq("clr.errors0", 32'(ec_o[0]), 0);
    check_eq("clr.code0", 32'(code_o[0]), 0);
    arm();

    // Masked full-group fault: counted only by the unmasked checker
    step(1'b1, 1'b0, 16'h0055);
    flt[5] = 1'b1;
    step(1'b0, 1'b0, '0);
    check_eq("mask.errors0", 32'(ec_o[0]), 1);
    check_eq("mask.code0", 32'(code_o[0]), 6);
    check_eq("mask.errors1", 32'(ec_o[1]), 0);

    // Mid-run DUT reset with 5 entries
    for (int v = 0; v < 4; v++) step(1'b1, 1'b0, DW'(16'h0400 + v));
    check_eq("mid.shadow5", 32'(shc_o[0]), 5);
    dut_rst_n = 1'b0;
    step(1'b1, 1'b1, 16'h0777);
    dut_rst_n = 1'b1;
    idle(3);
    check_eq("mid.shadow0", 32'(shc_o[0]), 0);
    check_eq("mid.errors0", 32'(ec_o[0]), 1);

    // Random traffic with occasional DUT resets and pin faults
    for (int n = 0; n < 400; n++) begin
      dut_rst_n = ($urandom_range(0, 49) != 0);
      if ($urandom_range(0, 29) == 0) begin
        k = $urandom_range(0, 7);
        flt[k] = 1'b1;
      end
      rv = DW'($urandom());
      step(1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), rv);
    end
    dut_rst_n = 1'b1;
    idle(1);
    check_eq("sat.correct0", 32'(cc_o[0]), SATMAX);

    clr_counts = 1'b1;
    step(1'b0, 1'b0, '0);
    clr_counts = 1'b0;
    check_eq("end.correct0", 32'(cc_o[0]), 0);
    check_eq("end.cycle0", 32'(fec_o[0]), 0);
    check_eq("end.state0", 32'(st_o[0]), 0);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
`default_nettype wire
